// File: rtl/wptr_ctrl_lvl.sv
// Write-domain pointer controller for an async FIFO: binary/Gray write pointer,
// registered full flag, fill level, almost-full, sticky overflow and drop counter.
module wptr_ctrl_lvl #(
  parameter int ADDR_LEN = 8,
  parameter int CNT_W    = 8
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                wincr_i,
  input  logic [ADDR_LEN:0]   r2wptr_sync_i,
  input  logic [ADDR_LEN:0]   afull_thresh_i,
  input  logic                wovf_clr_i,
  output logic                wen_o,
  output logic [ADDR_LEN-1:0] fifo_waddr_o,
  output logic [ADDR_LEN:0]   wptr_o,
  output logic                wfull_o,
  output logic [ADDR_LEN:0]   wlevel_o,
  output logic                walmost_full_o,
  output logic                woverflow_o,
  output logic [CNT_W-1:0]    wdrop_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [ADDR_LEN:0] gray2bin(input logic [ADDR_LEN:0] g);
    logic [ADDR_LEN:0] b;
    b[ADDR_LEN] = g[ADDR_LEN];
    for (int i = ADDR_LEN - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [ADDR_LEN:0] wbin;
  logic [ADDR_LEN:0] wbin_next;
  logic [ADDR_LEN:0] wgray_next;
  logic [ADDR_LEN:0] rbin;
  logic [ADDR_LEN:0] level_next;
  logic [ADDR_LEN:0] rptr_full_pat;
  logic              drop;

  assign wen_o         = wincr_i & ~wfull_o;
  assign drop          = wincr_i & wfull_o;
  assign wbin_next     = wbin + {{ADDR_LEN{1'b0}}, wen_o};
  assign wgray_next    = (wbin_next >> 1) ^ wbin_next;
  assign rbin          = gray2bin(r2wptr_sync_i);
  assign level_next    = wbin_next - rbin;
  assign fifo_waddr_o  = wbin[ADDR_LEN-1:0];
  // Full when the write pointer is exactly one lap ahead of the read pointer.
  assign rptr_full_pat = {~r2wptr_sync_i[ADDR_LEN:ADDR_LEN-1], r2wptr_sync_i[ADDR_LEN-2:0]};

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin           <= '0;
      wptr_o         <= '0;
      wfull_o        <= 1'b0;
      wlevel_o       <= '0;
      walmost_full_o <= 1'b0;
      woverflow_o    <= 1'b0;
      wdrop_cnt_o    <= '0;
    end else begin
      wbin           <= wbin_next;
      wptr_o         <= wgray_next;
      wfull_o        <= (wgray_next == rptr_full_pat);
      wlevel_o       <= level_next;
      walmost_full_o <= (level_next >= afull_thresh_i);
      // A drop wins over a coincident clear so no overflow is ever lost.
      if (drop) begin
        woverflow_o <= 1'b1;
      end else if (wovf_clr_i) begin
        woverflow_o <= 1'b0;
      end
      if (wovf_clr_i) begin
        wdrop_cnt_o <= drop ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      end else if (drop) begin
        wdrop_cnt_o <= sat_inc(wdrop_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_wptr_ctrl_lvl.sv
// Scoreboard bench for wptr_ctrl_lvl (ADDR_LEN=3, CNT_W=2): stimulus pushes
// expected registered outputs, a monitor pops and compares after each edge.
module tb_wptr_ctrl_lvl;
  localparam int A = 3;
  localparam int C = 2;
  localparam int DEPTH = 1 << A;
  localparam int MOD = 1 << (A + 1);
  localparam int CMAX = (1 << C) - 1;

  logic         wclk = 1'b0;
  logic         wrst_n = 1'b0;
  logic         wincr_i = 1'b0;
  logic [A:0]   r2wptr_sync_i = '0;
  logic [A:0]   afull_thresh_i = '0;
  logic         wovf_clr_i = 1'b0;
  logic         wen_o;
  logic [A-1:0] fifo_waddr_o;
  logic [A:0]   wptr_o;
  logic         wfull_o;
  logic [A:0]   wlevel_o;
  logic         walmost_full_o;
  logic         woverflow_o;
  logic [C-1:0] wdrop_cnt_o;

  always #5 wclk = ~wclk;

  wptr_ctrl_lvl #(.ADDR_LEN(A), .CNT_W(C)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .wincr_i(wincr_i), .r2wptr_sync_i(r2wptr_sync_i),
    .afull_thresh_i(afull_thresh_i), .wovf_clr_i(wovf_clr_i), .wen_o(wen_o),
    .fifo_waddr_o(fifo_waddr_o), .wptr_o(wptr_o), .wfull_o(wfull_o), .wlevel_o(wlevel_o),
    .walmost_full_o(walmost_full_o), .woverflow_o(woverflow_o), .wdrop_cnt_o(wdrop_cnt_o)
  );

  typedef struct {
    int waddr; int wptr; int full; int level; int afull; int ovf; int cnt;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Model: total accepted writes and the read position as plain integers.
  int wr = 0;
  int rd = 0;
  bit m_full = 0;
  bit m_ovf = 0;
  int m_cnt = 0;
  int hist[$];

  function automatic int gray(input int x);
    int b;
    b = x % MOD;
    return (b >> 1) ^ b;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit rn, input bit inc, input int rdc, input int th, input bit clr);
    exp_t e;
    bit wen, drop;
    int lvl;
    @(negedge wclk);
    wrst_n = rn; wincr_i = inc; rd = rdc;
    r2wptr_sync_i = 4'(gray(rdc)); afull_thresh_i = 4'(th); wovf_clr_i = clr;
    #1;
    if (!rn) begin
      wr = 0; m_full = 0; m_ovf = 0; m_cnt = 0;
      e = '{0, 0, 0, 0, 0, 0, 0};
    end else begin
      wen = inc && !m_full;
      drop = inc && m_full;
      chk("wen", int'(wen_o), int'(wen));
      wr += int'(wen);
      lvl = ((wr - rdc) % MOD + MOD) % MOD;
      m_full = (lvl == DEPTH);
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (clr) m_cnt = drop ? 1 : 0;
      else if (drop && m_cnt < CMAX) m_cnt++;
      e.waddr = wr % DEPTH; e.wptr = gray(wr); e.full = int'(m_full); e.level = lvl;
      e.afull = int'(lvl >= th); e.ovf = int'(m_ovf); e.cnt = m_cnt;
    end
    q.push_back(e);
  endtask

  // Monitor: compare registered outputs just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge wclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("waddr", int'(fifo_waddr_o), e.waddr);
        chk("wptr", int'(wptr_o), e.wptr);
        chk("wfull", int'(wfull_o), e.full);
        chk("wlevel", int'(wlevel_o), e.level);
        chk("walmost_full", int'(walmost_full_o), e.afull);
        chk("woverflow", int'(woverflow_o), e.ovf);
        chk("wdrop_cnt", int'(wdrop_cnt_o), e.cnt);
      end
    end
  end

  initial begin
    int rdc;
    int waited;
    // Reset with writes requested, release mid-stream, reassert.
    repeat (2) drive(0, 1, 0, 8, 0);
    repeat (3) drive(1, 1, 0, 8, 0);
    drive(0, 1, 0, 8, 0);
    // Fill to full with almost-full threshold 6.
    repeat (8) drive(1, 1, 0, 6, 0);
    // Overflow: three drops, clear, then clear coincident with a drop.
    repeat (3) drive(1, 1, 0, 6, 0);
    drive(1, 0, 0, 6, 1);
    drive(1, 1, 0, 6, 1);
    // Release: read side advances to 4.
    drive(1, 0, 4, 6, 0);
    drive(1, 0, 4, 6, 0);
    // Threshold 0 straight after reset, and threshold above depth.
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 9, 0);
    // Streaming with read pointer tracking two cycles late: wraps the pointers.
    drive(0, 0, 0, 2, 0);
    hist.delete();
    repeat (40) begin
      rdc = (hist.size() >= 2) ? hist[hist.size()-2] : 0;
      drive(1, 1, rdc, 2, 0);
      hist.push_back(wr);
    end
    // Freeze the read side, fill and drop past the counter limit.
    rdc = wr;
    repeat (13) drive(1, 1, rdc, 5, 0);
    drive(1, 0, rdc, 5, 1);
    // Randomized traffic with occasional clears and resets.
    rdc = 0;
    drive(0, 0, 0, 0, 0);
    repeat (300) begin
      if ($urandom_range(0, 99) == 0) begin
        rdc = 0;
        drive(0, $urandom_range(0, 1), 0, $urandom_range(0, 15), 0);
      end else begin
        if (wr > rdc) rdc += $urandom_range(0, wr - rdc);
        drive(1, $urandom_range(0, 3) != 0, rdc, $urandom_range(0, 15),
              $urandom_range(0, 15) == 0);
      end
    end
    @(negedge wclk);
    wincr_i = 0;
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge wclk);
      waited++;
    end
    if (q.size() > 0) chk("scoreboard_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wptr_ctrl_lvl.md
Name: wptr_ctrl_lvl

Overview:
Next-generation write-side pointer controller for the asynchronous FIFO. It sits in the write clock domain and drives the RAM write address and write enable. It also produces the Gray-coded write pointer handed to the read-domain synchronizer and a registered full flag. New versus the previous generation: a fill-level output, a programmable almost-full flag, a sticky overflow flag with clear, and a saturating dropped-write counter.

Parameters:
ADDR_LEN, 8, RAM address width; FIFO depth = 2**ADDR_LEN; legal range ADDR_LEN >= 2.
CNT_W, 8, width of the dropped-write counter.

Ports:
wclk  in  1  write-domain clock.
wrst_n  in  1  reset, synchronous, active-low (sampled on posedge wclk).
wincr_i  in  1  write request.
r2wptr_sync_i  in  ADDR_LEN+1  read pointer (Gray), already synchronized into wclk.
afull_thresh_i  in  ADDR_LEN+1  almost-full threshold, in words, quasi-static.
wovf_clr_i  in  1  clears woverflow_o and wdrop_cnt_o.
wen_o  out  1  RAM write enable, combinational: wincr_i & !wfull_o.
fifo_waddr_o  out  ADDR_LEN  RAM write address (binary).
wptr_o  out  ADDR_LEN+1  registered Gray write pointer.
wfull_o  out  1  registered full flag.
wlevel_o  out  ADDR_LEN+1  registered fill level, 0..2**ADDR_LEN.
walmost_full_o  out  1  registered: level >= afull_thresh_i.
woverflow_o  out  1  sticky: a write was attempted while full.
wdrop_cnt_o  out  CNT_W  saturating count of rejected writes.

Behaviour:
- One clock domain; all state changes on posedge wclk.
- Reset: when wrst_n=0 at an edge, all registers clear at that edge. Every registered output becomes 0; fifo_waddr_o=0. Reset has priority over all other inputs. Reset mid-operation discards pointer state with no partial update.
- Binary write counter wbin: ADDR_LEN+1 bits, wraps modulo 2**(ADDR_LEN+1).
  - wbin_next = wbin + wen_o.
  - fifo_waddr_o = wbin[ADDR_LEN-1:0].
- Gray pointer: wgray_next = (wbin_next>>1) ^ wbin_next; wptr_o <= wgray_next.
- Full: wfull_o <= (wgray_next == {~r2wptr_sync_i[ADDR_LEN:ADDR_LEN-1], r2wptr_sync_i[ADDR_LEN-2:0]}).
- Read binary: rbin = Gray-to-binary of r2wptr_sync_i (combinational XOR prefix from MSB).
- Level: wlevel_o <= (wbin_next - rbin) mod 2**(ADDR_LEN+1). The level is pessimistic by synchronizer latency, never optimistic. wlevel_o == 2**ADDR_LEN exactly when wfull_o == 1 in the same cycle.
- Almost-full: walmost_full_o <= ((wbin_next - rbin) >= afull_thresh_i).
  - Threshold 0: flag is 1 from the first post-reset edge.
  - Threshold > 2**ADDR_LEN: flag is never set.
- Write latency: request accepted in cycle N (wen_o=1). fifo_waddr_o, wptr_o, wlevel_o and both flags reflect it after edge N.
- Drop: drop = wincr_i & wfull_o. Pointers are unchanged on a drop.
- Overflow flag:
  - woverflow_o <= drop ? 1 : (wovf_clr_i ? 0 : woverflow_o).
  - A simultaneous drop and clear leaves the flag at 1.
- Drop counter:
  - wovf_clr_i & !drop -> 0.
  - wovf_clr_i & drop -> 1.
  - drop only -> wdrop_cnt_o+1, saturating at 2**CNT_W-1.
  - otherwise hold.
- Full release: when r2wptr_sync_i advances while full, wfull_o drops at the next edge. A write in the same cycle is still blocked because wen_o uses the registered wfull_o.
- Wrap-around: counter and Gray pointer wrap from all-ones to 0 with no discontinuity in wlevel_o.

Test Plan:
1. Reset: ADDR_LEN=3, wincr_i=1, wrst_n=0 for 2 edges -> all outputs 0, fifo_waddr_o=0. Release wrst_n mid-stream -> first write takes effect at the next edge. Reassert after 3 writes -> outputs back to 0 at the following edge.
2. Fill: r2wptr_sync_i=0, wincr_i=1 for 8 cycles -> after edge 8: wfull_o=1, wptr_o=4'b1100, wlevel_o=8, fifo_waddr_o=0, wen_o=0.
3. Almost-full: afull_thresh_i=6 during scenario 2 -> walmost_full_o=0 after edge 5, 1 after edge 6, wlevel_o=6.
4. Overflow: from full, wincr_i=1 for 3 more cycles -> pointers frozen, woverflow_o=1, wdrop_cnt_o=3. Pulse wovf_clr_i with wincr_i=0 -> both 0. Clear coincident with a drop -> woverflow_o=1, wdrop_cnt_o=1.
5. Drain/release: from full, set r2wptr_sync_i=4'b0110 (bin 4), wincr_i=0 -> next edge wfull_o=0, wlevel_o=4, walmost_full_o=0 (threshold 6).
6. Wrap and saturation: CNT_W=2, stream 40 writes with r2wptr_sync_i tracking wptr_o 2 cycles late -> no false full, wlevel_o <= 2, clean Gray wrap at 4'b1000->4'b0000. Then force full and 5 drops -> wdrop_cnt_o=3.
